// File: rtl/tm_input_conditioner.sv
// Turing-machine front panel input conditioner: synchronizes the raw switches and buttons and queues Next entries in a FIFO.
// Optional button debounce is enabled by defining TM_INPUT_DEBOUNCE_EN.

module tm_btn_cond #(
  parameter int D = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic evt
);
  logic s1, s2, deb, deb_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb_q <= 1'b0;
      evt   <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      deb_q <= deb;
      evt   <= deb & ~deb_q;
    end
  end

  generate
    if (D > 0) begin : g_deb
      localparam int CW = $clog2(D + 1);
      logic [CW-1:0] cnt;
      logic          lvl;

      // Any cycle where the synchronized level agrees with the accepted level restarts the count.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          lvl <= 1'b0;
          cnt <= '0;
        end else if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == CW'(D - 1)) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      assign deb = lvl;
    end else begin : g_nodeb
      assign deb = s2;
    end
  endgenerate
endmodule

module tm_input_conditioner #(
  parameter int DATA_W          = 6,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          next_btn,
  input  logic                          done_btn,
  input  logic [DATA_W-1:0]             input_data,
  output logic [DATA_W-1:0]             entry_data,
  output logic                          entry_valid,
  input  logic                          entry_ready,
  output logic                          done_pulse,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
`ifdef TM_INPUT_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int DEB_D = DEB_EN ? DEBOUNCE_CYCLES : 0;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  logic [1:0]        btn_raw, btn_evt;
  logic [DATA_W-1:0] d_s1, d_s2;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              done_pending;
  logic              push, pop, full, wr_en;

  assign btn_raw = {done_btn, next_btn};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_btn
      tm_btn_cond #(.D(DEB_D)) u_btn (
        .clock (clock),
        .reset (reset),
        .btn   (btn_raw[i]),
        .evt   (btn_evt[i])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_s1 <= '0;
      d_s2 <= '0;
    end else begin
      d_s1 <= input_data;
      d_s2 <= d_s1;
    end
  end

  assign push  = btn_evt[0];
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = entry_valid & entry_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= d_s2;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      done_pending <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push & full & ~pop) overflow <= 1'b1;
      // A Done arriving while one is already pending (even on its pulse cycle) is absorbed.
      done_pending <= done_pulse ? 1'b0 : (done_pending | btn_evt[1]);
    end
  end

  assign entry_valid = (count != '0);
  assign entry_data  = entry_valid ? mem[rd_ptr] : '0;
  assign done_pulse  = done_pending & ~entry_valid & ~push;
  assign fifo_count  = count;
endmodule

// File: tb/tb_tm_input_conditioner.sv
// Scoreboard bench for tm_input_conditioner; expected entries are queued at press time and checked on each pop.
module tb_tm_input_conditioner;
  localparam int DATA_W = 6;
  localparam int DEB    = 2;
  localparam int DEPTH  = 4;
`ifdef TM_INPUT_DEBOUNCE_EN
  localparam int D = DEB;
`else
  localparam int D = 0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              next_btn = 1'b0;
  logic              done_btn = 1'b0;
  logic              entry_ready = 1'b0;
  logic [DATA_W-1:0] input_data = '0;
  logic [DATA_W-1:0] entry_data;
  logic              entry_valid, done_pulse, overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int dones = 0;
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] mon_exp;

  tm_input_conditioner #(.DATA_W(DATA_W), .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .next_btn    (next_btn),
    .done_btn    (done_btn),
    .input_data  (input_data),
    .entry_data  (entry_data),
    .entry_valid (entry_valid),
    .entry_ready (entry_ready),
    .done_pulse  (done_pulse),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  always #5 clock = ~clock;

  // Monitor: every pop is checked against the scoreboard head; every done_pulse cycle is counted.
  always @(negedge clock) begin
    if (reset) begin
      if (entry_valid && entry_ready) begin
        pops++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL pop_unexpected: got entry_data=%0d, required no entry", entry_data);
        end else begin
          mon_exp = sb.pop_front();
          if (entry_data !== mon_exp) begin
            fails++;
            $display("FAIL pop_data: got %0d, required %0d", entry_data, mon_exp);
          end
        end
      end
      if (done_pulse) begin
        dones++;
        tests++;
        if (sb.size() != 0 || entry_valid !== 1'b0) begin
          fails++;
          $display("FAIL done_early: got pulse with %0d entries pending, required 0", sb.size());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [DATA_W-1:0] v, input int hold, input bit exp);
    input_data = v;
    next_btn   = 1'b1;
    if (exp) sb.push_back(v);
    step(hold);
    next_btn = 1'b0;
    step(D + 5);
  endtask

  task automatic press_done(input int hold);
    done_btn = 1'b1;
    step(hold);
    done_btn = 1'b0;
    step(D + 5);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    entry_ready = 1'b0;
    next_btn = 1'b0;
    done_btn = 1'b0;
    sb.delete();
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    @(negedge clock);
    tests++; if (fifo_count !== 0) begin fails++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
    tests++; if (entry_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", entry_valid); end
    tests++; if (entry_data !== '0) begin fails++; $display("FAIL reset_data: got %0d, required 0", entry_data); end
    tests++; if (done_pulse !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done_pulse); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    step(1);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    int p0;
    apply_reset();
    entry_ready = 1'b1;
    p0 = pops;
    input_data = 6'd3;
    next_btn = 1'b1;
    sb.push_back(6'd3);
    step(3 + D);
    @(negedge clock);
    tests++; if (entry_valid !== 1'b0) begin fails++; $display("FAIL latency_early: got valid=%b at k+%0d, required 0", entry_valid, 2 + D); end
    @(negedge clock);
    tests++; if (entry_valid !== 1'b1) begin fails++; $display("FAIL latency_rise: got valid=%b at k+%0d, required 1", entry_valid, 3 + D); end
    step(2);
    next_btn = 1'b0;
    step(D + 8);
    tests++; if (pops - p0 !== 1) begin fails++; $display("FAIL single_pops: got %0d, required 1", pops - p0); end
    tests++; if (fifo_count !== 0) begin fails++; $display("FAIL single_count: got %0d, required 0", fifo_count); end
    entry_ready = 1'b0;
  endtask

  task automatic test_glitch();
    int exp_cnt;
    apply_reset();
    exp_cnt = (D >= 2) ? 0 : 1;
    input_data = 6'd9;
    if (exp_cnt == 1) sb.push_back(6'd9);
    next_btn = 1'b1;
    step(1);
    next_btn = 1'b0;
    step(D + 6);
    tests++; if (fifo_count !== exp_cnt) begin fails++; $display("FAIL glitch_count: got %0d, required %0d", fifo_count, exp_cnt); end
    entry_ready = 1'b1;
    step(4);
    entry_ready = 1'b0;
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL glitch_drain: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 6; i++) press(DATA_W'(i), D + 2, i <= 4);
    tests++; if (fifo_count !== 4) begin fails++; $display("FAIL ovf_count: got %0d, required 4", fifo_count); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    tests++; if (entry_data !== 6'd1) begin fails++; $display("FAIL ovf_head: got %0d, required 1", entry_data); end
    entry_ready = 1'b1;
    step(8);
    entry_ready = 1'b0;
    tests++; if (fifo_count !== 0) begin fails++; $display("FAIL ovf_drain: got %0d, required 0", fifo_count); end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL ovf_sb: got %0d left, required 0", sb.size()); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_simul();
    apply_reset();
    for (int i = 8; i <= 11; i++) press(DATA_W'(i), D + 2, 1'b1);
    tests++; if (fifo_count !== 4) begin fails++; $display("FAIL simul_fill: got %0d, required 4", fifo_count); end
    input_data = 6'd7;
    next_btn = 1'b1;
    sb.push_back(6'd7);
    step(3 + D);
    entry_ready = 1'b1;
    step(1);
    entry_ready = 1'b0;
    next_btn = 1'b0;
    @(negedge clock);
    tests++; if (fifo_count !== 4) begin fails++; $display("FAIL simul_count: got %0d, required 4", fifo_count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL simul_ovf: got %b, required 0", overflow); end
    step(D + 4);
    entry_ready = 1'b1;
    step(8);
    entry_ready = 1'b0;
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL simul_drain: got %0d left, required 0", sb.size()); end
    tests++; if (fifo_count !== 0) begin fails++; $display("FAIL simul_empty: got %0d, required 0", fifo_count); end
  endtask

  task automatic test_done();
    int d0;
    apply_reset();
    d0 = dones;
    press(6'd20, D + 2, 1'b1);
    press(6'd21, D + 2, 1'b1);
    press_done(D + 2);
    press_done(D + 2);
    tests++; if (dones - d0 !== 0) begin fails++; $display("FAIL done_hold: got %0d pulses, required 0", dones - d0); end
    tests++; if (fifo_count !== 2) begin fails++; $display("FAIL done_count: got %0d, required 2", fifo_count); end
    entry_ready = 1'b1;
    step(10);
    entry_ready = 1'b0;
    tests++; if (dones - d0 !== 1) begin fails++; $display("FAIL done_single: got %0d pulse cycles, required 1", dones - d0); end
  endtask

  task automatic test_next_done();
    int d0;
    apply_reset();
    d0 = dones;
    input_data = 6'd30;
    sb.push_back(6'd30);
    next_btn = 1'b1;
    done_btn = 1'b1;
    step(D + 2);
    next_btn = 1'b0;
    done_btn = 1'b0;
    step(D + 6);
    tests++; if (fifo_count !== 1) begin fails++; $display("FAIL nd_count: got %0d, required 1", fifo_count); end
    tests++; if (dones - d0 !== 0) begin fails++; $display("FAIL nd_early: got %0d pulses, required 0", dones - d0); end
    entry_ready = 1'b1;
    step(4);
    entry_ready = 1'b0;
    tests++; if (dones - d0 !== 1) begin fails++; $display("FAIL nd_pulse: got %0d pulses, required 1", dones - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    apply_reset();
    for (int i = 1; i <= 3; i++) press(DATA_W'(i + 40), D + 2, 1'b1);
    press_done(D + 2);
    tests++; if (fifo_count !== 3) begin fails++; $display("FAIL mid_fill: got %0d, required 3", fifo_count); end
    reset = 1'b0;
    @(negedge clock);
    tests++; if (fifo_count !== 0) begin fails++; $display("FAIL mid_count: got %0d, required 0", fifo_count); end
    tests++; if (entry_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b, required 0", entry_valid); end
    tests++; if (entry_data !== '0) begin fails++; $display("FAIL mid_data: got %0d, required 0", entry_data); end
    step(1);
    sb.delete();
    reset = 1'b1;
    d0 = dones;
    step(10);
    tests++; if (fifo_count !== 0) begin fails++; $display("FAIL mid_after: got %0d, required 0", fifo_count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_ovf: got %b, required 0", overflow); end
    tests++; if (dones - d0 !== 0) begin fails++; $display("FAIL mid_done: got %0d pulses, required 0", dones - d0); end
  endtask

  task automatic test_held_reset();
    reset = 1'b0;
    entry_ready = 1'b0;
    sb.delete();
    input_data = 6'd5;
    next_btn = 1'b1;
    step(2);
    sb.push_back(6'd5);
    reset = 1'b1;
    step(D + 6);
    tests++; if (fifo_count !== 1) begin fails++; $display("FAIL held_event: got %0d, required 1", fifo_count); end
    next_btn = 1'b0;
    step(D + 6);
    tests++; if (fifo_count !== 1) begin fails++; $display("FAIL held_release: got %0d, required 1", fifo_count); end
    entry_ready = 1'b1;
    step(3);
    entry_ready = 1'b0;
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL held_drain: got %0d left, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_overflow();
    test_simul();
    test_done();
    test_next_done();
    test_reset_mid();
    test_held_reset();
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tm_input_conditioner.md
TM_INPUT_CONDITIONER -- requirements
Module: tm_input_conditioner

Interface
REQ-001 Parameter DATA_W, default 6: width of switch data and of each entry.
REQ-002 Parameter DEBOUNCE_CYCLES, default 2: number of consecutive stable cycles needed to accept a button level change.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two): number of buffered entries.
REQ-004 clock  in  1: single clock; the whole block is synchronous to its rising edge.
REQ-005 reset  in  1: asynchronous, active-low reset.
REQ-006 next_btn  in  1: raw Next button, asynchronous level.
REQ-007 done_btn  in  1: raw Done button, asynchronous level.
REQ-008 input_data  in  DATA_W: raw switch value, asynchronous.
REQ-009 entry_data  out  DATA_W: FIFO head entry; 0 when the FIFO is empty.
REQ-010 entry_valid  out  1: FIFO is not empty.
REQ-011 entry_ready  in  1: downstream Turing-machine controller accepts the head entry.
REQ-012 done_pulse  out  1: one-cycle Done event for the downstream controller.
REQ-013 overflow  out  1: sticky flag; an entry was dropped because the FIFO was full.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1: current number of stored entries.

Function
REQ-015 next_btn, done_btn and every input_data bit SHALL each pass through a 2-flop synchronizer.
REQ-016 Debouncer, per button: the debounced level SHALL take the synchronized level after that level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-017 A Next event SHALL be a 0->1 transition of debounced Next; holding or releasing the button SHALL produce no further event.
REQ-018 On a Next event the synchronized input_data SHALL be pushed into the FIFO. Latency: next_btn sampled high at edge k gives entry_valid=1 after edge k+3+D, where D=DEBOUNCE_CYCLES, or D=0 when debounce is compiled out.
REQ-019 A pop SHALL occur on a cycle where entry_valid and entry_ready are both 1; the next entry SHALL appear on the following cycle.
REQ-020 If a push arrives while the FIFO is full and no pop occurs in that cycle, the entry SHALL be dropped and overflow SHALL be set.
REQ-021 A push and a pop in the same cycle SHALL both take effect and leave fifo_count unchanged; when full, the push SHALL be accepted.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH. fifo_count SHALL never exceed FIFO_DEPTH and never drop below 0.
REQ-023 A Done event SHALL set done_pending. done_pulse SHALL assert for exactly one cycle on the first cycle where done_pending=1 and the FIFO is empty with no push in that cycle; done_pending SHALL then clear.
REQ-024 A second Done event while done_pending=1 SHALL be absorbed, producing a single done_pulse.
REQ-025 Next and Done events in the same cycle SHALL push the entry first; done_pulse SHALL follow only after that entry is popped.
REQ-026 entry_ready while entry_valid=0 SHALL have no effect.

Reset
REQ-027 While reset=0: synchronizers, debounced levels, counters, pointers, done_pending and overflow SHALL be 0; entry_valid=0, entry_data=0, done_pulse=0, fifo_count=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries and any pending Done immediately.
REQ-029 A button already held high when reset deasserts SHALL produce one event once debounced.

Configuration
REQ-030 With macro TM_INPUT_DEBOUNCE_EN defined, the REQ-016 debouncers SHALL be present.
REQ-031 Without TM_INPUT_DEBOUNCE_EN, the debounced level SHALL equal the synchronized level (D=0); all other behaviour SHALL be unchanged.

Verification
REQ-032 Scenario, single entry: input_data=3, Next high for 6 cycles, entry_ready=1 -> exactly one pop with entry_data=3, and entry_valid rises k+3+D.
REQ-033 Scenario, glitch rejection: Next high for 1 cycle with debounce enabled and D=2 -> no push, fifo_count stays 0.
REQ-034 Scenario, overflow: entry_ready=0, six presses with data 1..6, depth 4 -> fifo_count=4 and overflow=1; pops return 1,2,3,4 in order.
REQ-035 Scenario, simultaneous push/pop: FIFO full with entry_ready=1 and a new press of 7 -> count stays 4, no overflow, and 7 pops last.
REQ-036 Scenario, Done ordering: two entries queued with entry_ready=0, then Done pressed -> done_pulse=0 until both entries are popped, then exactly one 1-cycle done_pulse.
REQ-037 Scenario, reset mid-fill: 3 entries queued, reset pulsed low -> fifo_count=0, entry_valid=0, overflow=0, no done_pulse.
